// File: rtl/alu_issue.sv
// Issue buffer between register read and the ALU: decodes an instruction,
// queues {data1, data2, ALUCtrl, rd} in a 2-entry in-order FIFO, and drops
// illegal encodings while pulsing illegal_o and bumping a saturating counter.
module alu_issue #(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              inst_valid_i,
    output logic              inst_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [31:0]       rs_data_i,
    input  logic [31:0]       rt_data_i,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output logic [31:0]       data1_o,
    output logic [31:0]       data2_o,
    output logic [2:0]        ALUCtrl_o,
    output logic [4:0]        rd_addr_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  illegal_cnt_o,
    output logic [1:0]        occupancy_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned OCC_W  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [CTRL_W-1:0] ctrl;
        logic [ADDR_W-1:0] rd;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [OCC_W-1:0]   count_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   illegal_cnt_q;

    entry_t             dec_c;
    logic               legal_c;
    logic               enq_c;
    logic               enq_legal_c;
    logic               enq_illegal_c;
    logic               deq_c;
    entry_t             head_c;

    // Source-register addresses and shamt play no part in this stage.
    logic unused_inst_bits_c;
    assign unused_inst_bits_c = &{1'b0, inst_i[25:21], inst_i[10:6]};

    // Decode opcode/funct into ALU control and operand selection.
    always_comb begin
        legal_c       = 1'b0;
        dec_c         = '0;
        dec_c.data1   = rs_data_i;
        unique case (inst_i[31:26])
            6'b000000: begin
                dec_c.data2 = rt_data_i;
                dec_c.rd    = inst_i[15:11];
                legal_c     = 1'b1;
                unique case (inst_i[5:0])
                    6'b100000: dec_c.ctrl = 3'b010;
                    6'b100010: dec_c.ctrl = 3'b110;
                    6'b100100: dec_c.ctrl = 3'b000;
                    6'b100101: dec_c.ctrl = 3'b001;
                    6'b011000: dec_c.ctrl = 3'b011;
                    6'b101010: dec_c.ctrl = 3'b111;
                    default:   legal_c    = 1'b0;
                endcase
            end
            6'b001000: begin
                dec_c.data2 = {{16{inst_i[15]}}, inst_i[15:0]};
                dec_c.rd    = inst_i[20:16];
                dec_c.ctrl  = 3'b010;
                legal_c     = 1'b1;
            end
            default: legal_c = 1'b0;
        endcase
    end

    assign inst_ready_o  = (count_q != OCC_W'(DEPTH));
    assign issue_valid_o = (count_q != '0);
    assign occupancy_o   = count_q;

    assign enq_c         = inst_valid_i && inst_ready_o && !flush_i;
    assign enq_legal_c   = enq_c && legal_c;
    assign enq_illegal_c = enq_c && !legal_c;
    assign deq_c         = issue_valid_o && issue_ready_i && !flush_i;

    // FIFO pointers, count and illegal-beat reporting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= '0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_q <= enq_illegal_c;
            if (enq_illegal_c && (illegal_cnt_q != '1)) begin
                illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
            end
            if (flush_i) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                count_q  <= '0;
            end else begin
                if (enq_legal_c) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (deq_c) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_q + OCC_W'(enq_legal_c) - OCC_W'(deq_c);
            end
        end
    end

    // Entry storage; contents are only visible while counted as valid.
    always_ff @(posedge clk_i) begin
        if (enq_legal_c) begin
            mem_q[wr_ptr_q] <= dec_c;
        end
    end

    assign head_c        = mem_q[rd_ptr_q];
    assign data1_o       = issue_valid_o ? head_c.data1 : '0;
    assign data2_o       = issue_valid_o ? head_c.data2 : '0;
    assign ALUCtrl_o     = issue_valid_o ? head_c.ctrl  : '0;
    assign rd_addr_o     = issue_valid_o ? head_c.rd    : '0;
    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic [31:0] inst_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic [2:0]  ALUCtrl_o;
    logic [4:0]  rd_addr_o;
    logic        illegal_o;
    logic [7:0]  illegal_cnt_o;
    logic [1:0]  occupancy_o;

    alu_issue #(.CNT_W(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .inst_valid_i  (inst_valid_i),
        .inst_ready_o  (inst_ready_o),
        .inst_i        (inst_i),
        .rs_data_i     (rs_data_i),
        .rt_data_i     (rt_data_i),
        .issue_valid_o (issue_valid_o),
        .issue_ready_i (issue_ready_i),
        .data1_o       (data1_o),
        .data2_o       (data2_o),
        .ALUCtrl_o     (ALUCtrl_o),
        .rd_addr_o     (rd_addr_o),
        .illegal_o     (illegal_o),
        .illegal_cnt_o (illegal_cnt_o),
        .occupancy_o   (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
    } m_entry_t;

    int total = 0;
    int bad   = 0;

    m_entry_t mq[$];
    bit       m_ill = 1'b0;
    int       m_cnt = 0;
    int       m_deq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction table.
    function automatic bit ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                      input logic [31:0] rt, output m_entry_t e);
        logic [5:0] op;
        logic [5:0] fn;
        int code;
        op   = ins[31:26];
        fn   = ins[5:0];
        e.d1 = rs;
        e.d2 = rt;
        e.rd = ins[15:11];
        e.ctrl = 3'd0;
        code = -1;
        if (op == 6'd8) begin
            e.d2 = 32'($signed(ins[15:0]));
            e.rd = ins[20:16];
            code = 2;
        end else if (op == 6'd0) begin
            if      (fn == 6'd32) code = 2;
            else if (fn == 6'd34) code = 6;
            else if (fn == 6'd36) code = 0;
            else if (fn == 6'd37) code = 1;
            else if (fn == 6'd24) code = 3;
            else if (fn == 6'd42) code = 7;
        end
        if (code < 0) return 1'b0;
        e.ctrl = 3'(code);
        return 1'b1;
    endfunction

    // Reference model: advance on each clock edge, clear on reset.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mq.delete();
            m_ill = 1'b0;
            m_cnt = 0;
        end else begin
            bit acc;
            bit take;
            m_entry_t e;
            acc   = inst_valid_i && (mq.size() < 2) && !flush_i;
            take  = (mq.size() > 0) && issue_ready_i && !flush_i;
            m_ill = 1'b0;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (take) begin
                    void'(mq.pop_front());
                    m_deq++;
                end
                if (acc) begin
                    if (ref_decode(inst_i, rs_data_i, rt_data_i, e)) begin
                        mq.push_back(e);
                    end else begin
                        m_ill = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_i) begin
        m_entry_t h;
        h = '{32'd0, 32'd0, 3'd0, 5'd0};
        if (mq.size() > 0) h = mq[0];
        chk("issue_valid", 32'(issue_valid_o), 32'(mq.size() != 0));
        chk("inst_ready",  32'(inst_ready_o),  32'(mq.size() != 2));
        chk("occupancy",   32'(occupancy_o),   32'(mq.size()));
        chk("data1",       data1_o,            h.d1);
        chk("data2",       data2_o,            h.d2);
        chk("ctrl",        32'(ALUCtrl_o),     32'(h.ctrl));
        chk("rd",          32'(rd_addr_o),     32'(h.rd));
        chk("illegal",     32'(illegal_o),     32'(m_ill));
        chk("illegal_cnt", 32'(illegal_cnt_o), 32'(m_cnt));
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        inst_valid_i = 1'b1;
        inst_i       = ins;
        rs_data_i    = rs;
        rt_data_i    = rt;
    endtask

    task automatic drain();
        inst_valid_i  = 1'b0;
        issue_ready_i = 1'b1;
        repeat (3) tick();
        issue_ready_i = 1'b0;
    endtask

    initial begin
        int ones;
        int vis;
        int deq_before;

        rst_i         = 1'b0;
        flush_i       = 1'b0;
        inst_valid_i  = 1'b0;
        inst_i        = 32'h0;
        rs_data_i     = 32'h0;
        rt_data_i     = 32'h0;
        issue_ready_i = 1'b0;
        repeat (2) tick();
        chk("rst_ready",  32'(inst_ready_o),  32'd1);
        chk("rst_valid",  32'(issue_valid_o), 32'd0);
        chk("rst_cnt",    32'(illegal_cnt_o), 32'd0);
        chk("rst_data1",  data1_o,            32'd0);
        rst_i = 1'b1;
        tick();

        // single add
        offer(32'h00221820, 32'd5, 32'd7);
        tick();
        inst_valid_i = 1'b0;
        chk("add_valid", 32'(issue_valid_o), 32'd1);
        chk("add_d1",    data1_o,            32'd5);
        chk("add_d2",    data2_o,            32'd7);
        chk("add_ctrl",  32'(ALUCtrl_o),     32'd2);
        chk("add_rd",    32'(rd_addr_o),     32'd3);
        drain();

        // addi with negative immediate
        offer(32'h2022FFFF, 32'd10, 32'h12345678);
        tick();
        inst_valid_i = 1'b0;
        chk("addi_d1",   data1_o,        32'd10);
        chk("addi_d2",   data2_o,        32'hFFFFFFFF);
        chk("addi_ctrl", 32'(ALUCtrl_o), 32'd2);
        chk("addi_rd",   32'(rd_addr_o), 32'd2);
        drain();

        // backpressure: sub, and, or back to back
        offer(32'h00221822, 32'd20, 32'd3);
        tick();
        offer(32'h00221824, 32'd12, 32'd10);
        tick();
        chk("bp_ready0", 32'(inst_ready_o), 32'd0);
        chk("bp_occ2",   32'(occupancy_o),  32'd2);
        offer(32'h00221825, 32'd4, 32'd1);
        tick();
        chk("bp_hold_occ", 32'(occupancy_o), 32'd2);
        chk("bp_head_sub", 32'(ALUCtrl_o),   32'd6);
        issue_ready_i = 1'b1;
        tick();
        chk("bp_ready_back", 32'(inst_ready_o), 32'd1);
        chk("bp_head_and",   32'(ALUCtrl_o),    32'd0);
        tick();
        inst_valid_i = 1'b0;
        chk("bp_head_or", 32'(ALUCtrl_o), 32'd1);
        chk("bp_or_d1",   data1_o,        32'd4);
        tick();
        chk("bp_empty", 32'(issue_valid_o), 32'd0);
        issue_ready_i = 1'b0;

        // illegal burst saturates the counter
        issue_ready_i = 1'b1;
        offer(32'hFC000000, 32'd1, 32'd2);
        ones = 0;
        vis  = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (illegal_o) ones++;
            if (issue_valid_o) vis++;
            if (i == 253) chk("ill_cnt_254", 32'(illegal_cnt_o), 32'd254);
        end
        inst_valid_i = 1'b0;
        chk("ill_pulses", 32'(ones), 32'd300);
        chk("ill_novalid", 32'(vis), 32'd0);
        chk("ill_sat", 32'(illegal_cnt_o), 32'd255);
        tick();
        chk("ill_pulse_end", 32'(illegal_o), 32'd0);
        issue_ready_i = 1'b0;

        // flush while full with a beat offered and the ALU ready
        offer(32'h00221820, 32'd1, 32'd1);
        tick();
        offer(32'h00221822, 32'd2, 32'd2);
        tick();
        chk("fl_occ2", 32'(occupancy_o), 32'd2);
        deq_before    = m_deq;
        flush_i       = 1'b1;
        issue_ready_i = 1'b1;
        offer(32'h00223825, 32'd9, 32'd9);
        tick();
        flush_i      = 1'b0;
        inst_valid_i = 1'b0;
        chk("fl_occ0",   32'(occupancy_o),   32'd0);
        chk("fl_valid0", 32'(issue_valid_o), 32'd0);
        chk("fl_nodeq",  32'(m_deq),         32'(deq_before));
        vis = 0;
        repeat (3) begin
            tick();
            if (issue_valid_o) vis++;
        end
        chk("fl_never_issued", 32'(vis), 32'd0);
        // flushed illegal beat raises no pulse
        flush_i = 1'b1;
        offer(32'hFC000000, 32'd0, 32'd0);
        tick();
        flush_i      = 1'b0;
        inst_valid_i = 1'b0;
        chk("fl_no_ill", 32'(illegal_o), 32'd0);
        issue_ready_i = 1'b0;

        // asynchronous reset between edges
        offer(32'h00221820, 32'd3, 32'd4);
        tick();
        inst_valid_i = 1'b0;
        chk("ar_occ1", 32'(occupancy_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar_valid0", 32'(issue_valid_o), 32'd0);
        chk("ar_ready1", 32'(inst_ready_o),  32'd1);
        chk("ar_cnt0",   32'(illegal_cnt_o), 32'd0);
        tick();
        rst_i = 1'b1;
        offer(32'h0022182A, 32'd6, 32'd8);
        tick();
        inst_valid_i = 1'b0;
        chk("slt_valid", 32'(issue_valid_o), 32'd1);
        chk("slt_ctrl",  32'(ALUCtrl_o),     32'd7);
        chk("slt_rd",    32'(rd_addr_o),     32'd3);

        // mul through full-throughput streaming
        issue_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            offer(32'h00221818 | 32'(i << 11), 32'(i), 32'(i + 100));
            tick();
            chk("stream_occ", 32'(occupancy_o), 32'd1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
